m_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the decode/execute datapath (imm generator, register file, ALU adder).
- Owns the PC. Issues word fetches to instruction memory over a req/ack handshake and buffers fetched {pc, ir} pairs in a 2-entry queue.
- Presents them downstream with valid/ready.
- Accepts a redirect (branch/jump target) that flushes all in-flight and buffered instructions.

---
 rtl/m_fetch_pkg.sv | 24 ++
 rtl/m_fetch_buf.sv | 66 ++++++
 rtl/m_fetch.sv | 92 +++++++++
 tb/tb_m_fetch.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/m_fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, reset defaults and
// the {pc, ir} buffer entry layout.
package m_fetch_pkg;

  localparam int unsigned IW = 32;

  localparam logic [IW-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [IW-1:0] NOP_IR_DEF   = 32'h0000_0013;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [IW-1:0] pc;
    logic [IW-1:0] ir;
  } fetch_entry_t;

  function automatic logic [IW-1:0] align_word(input logic [IW-1:0] addr);
    return {addr[IW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/m_fetch_buf.sv
// Two-entry {pc, ir} FIFO between instruction memory and decode.
// Clear wins over push/pop; pop on empty and push on full are ignored.
module m_fetch_buf
  import m_fetch_pkg::*;
(
  input  logic         w_clk,
  input  logic         w_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge w_clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/m_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding word fetches and feeds
// a two-entry buffer presented downstream with valid/ready.
//
//   state   | meaning
//   S_FETCH | normal fetch; request r_pc whenever the buffer has room
//   S_DRAIN | a stale request from before a redirect is waiting for its ack
module m_fetch
  import m_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_IR   = NOP_IR_DEF
) (
  input  logic          w_clk,
  input  logic          w_rst_n,
  output logic          w_imem_req,
  output logic [IW-1:0] w_imem_addr,
  input  logic          w_imem_ack,
  input  logic [IW-1:0] w_imem_rdata,
  input  logic          w_redirect,
  input  logic [IW-1:0] w_redirect_pc,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [IW-1:0] w_pc,
  output logic [IW-1:0] w_ir
);

  state_e        state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [IW-1:0] addr_q, addr_d;
  logic          pend_q, pend_d;

  logic          ack;
  logic          push, pop;
  fetch_entry_t  push_entry, head;
  logic [1:0]    count;

  always_comb begin
    w_imem_req  = w_rst_n && (pend_q || ((state_q == S_FETCH) && (count < 2'd2)));
    w_imem_addr = pend_q ? addr_q : pc_q;
    w_valid     = w_rst_n && (count != 2'd0);
    w_pc        = w_valid ? head.pc : (w_rst_n ? pc_q : RESET_PC);
    w_ir        = w_valid ? head.ir : NOP_IR;
  end

  always_comb begin
    ack        = w_imem_req && w_imem_ack;
    pop        = w_valid && w_ready && !w_redirect;
    push       = (state_q == S_FETCH) && ack && !w_redirect;
    push_entry = '{pc: pc_q, ir: w_imem_rdata};

    state_d = state_q;
    pc_d    = pc_q;
    // A raised request holds its address until acked, whatever count does.
    pend_d  = w_imem_req && !ack;
    addr_d  = w_imem_addr;

    if (w_redirect) begin
      pc_d    = align_word(w_redirect_pc);
      state_d = (w_imem_req && !ack) ? S_DRAIN : S_FETCH;
    end else if (state_q == S_DRAIN) begin
      if (ack) state_d = S_FETCH;
    end else if (ack) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  m_fetch_buf u_buf (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .push    (push),
    .pop     (pop),
    .clear   (w_redirect),
    .din     (push_entry),
    .head    (head),
    .count   (count)
  );

endmodule

// File: tb/tb_m_fetch.sv
// Bench for m_fetch: vector table, directed multi-cycle sequences, then
// randomized traffic checked against a queue-based reference model.
module tb_m_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        w_clk;
  logic        w_rst_n;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_rdata;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_pc;
  logic [31:0] w_ir;

  logic ack_en;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: answers only while a request is up.
  assign w_imem_ack   = ack_en & w_imem_req;
  assign w_imem_rdata = mem_f(w_imem_addr);

  m_fetch dut (
    .w_clk         (w_clk),
    .w_rst_n       (w_rst_n),
    .w_imem_req    (w_imem_req),
    .w_imem_addr   (w_imem_addr),
    .w_imem_ack    (w_imem_ack),
    .w_imem_rdata  (w_imem_rdata),
    .w_redirect    (w_redirect),
    .w_redirect_pc (w_redirect_pc),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_pc          (w_pc),
    .w_ir          (w_ir)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  always @(negedge w_clk) begin
    if (w_rst_n) assert (dut.u_buf.count_q != 2'd3) else $error("buffer count reached 3");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic rst, input logic ack, input logic rdy,
                     input logic rd, input logic [31:0] rpc, input logic e_req,
                     input logic [31:0] e_addr, input logic e_val, input logic [31:0] e_pc);
    @(negedge w_clk);
    w_rst_n = rst; ack_en = ack; w_ready = rdy; w_redirect = rd; w_redirect_pc = rpc;
    #1;
    chk({nm, " req"}, {31'b0, w_imem_req}, {31'b0, e_req});
    if (e_req) chk({nm, " addr"}, w_imem_addr, e_addr);
    chk({nm, " valid"}, {31'b0, w_valid}, {31'b0, e_val});
    if (!rst) begin
      chk({nm, " rst pc"}, w_pc, RST_PC);
      chk({nm, " rst ir"}, w_ir, NOP);
    end else if (e_val) begin
      chk({nm, " pc"}, w_pc, e_pc);
      chk({nm, " ir"}, w_ir, mem_f(e_pc));
    end else begin
      chk({nm, " nop ir"}, w_ir, NOP);
    end
  endtask

  typedef struct {
    logic        rst, ack, rdy, rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [17];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_paddr;
  logic        m_pend, m_drain;

  initial begin
    w_rst_n = 1'b0; ack_en = 1'b0; w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = '0;

    // rst ack rdy rd rpc | req addr valid pc
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  1'b1, 32'h8};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h8};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'hC};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'hC};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4,  1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8,  1'b1, 32'h4};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  1'b1, 32'h4};

    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ack, tbl[i].rdy, tbl[i].rd, tbl[i].rpc,
          tbl[i].e_req, tbl[i].e_addr, tbl[i].e_val, tbl[i].e_pc);
    end

    // Ack delayed three cycles: request held, single push.
    cyc("dly_rst", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("dly_w0",  1, 0, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("dly_w1",  1, 0, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("dly_w2",  1, 0, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("dly_ack", 1, 1, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("dly_out", 1, 0, 1, 0, 0, 1, 32'h4, 1, 32'h0);
    cyc("dly_dup", 1, 0, 1, 0, 0, 1, 32'h4, 0, 0);

    // Redirect while the 0x8 request is pending, drained and discarded.
    cyc("drn_rst", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("drn_c0",  1, 1, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("drn_c1",  1, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0);
    cyc("drn_c2",  1, 0, 1, 0, 0, 1, 32'h8, 1, 32'h4);
    cyc("drn_rd",  1, 0, 1, 1, 32'h103, 1, 32'h8, 0, 0);
    cyc("drn_hold",1, 0, 1, 0, 0, 1, 32'h8, 0, 0);
    cyc("drn_ack", 1, 1, 1, 0, 0, 1, 32'h8, 0, 0);
    cyc("drn_new", 1, 1, 1, 0, 0, 1, 32'h100, 0, 0);
    cyc("drn_out", 1, 1, 1, 0, 0, 1, 32'h104, 1, 32'h100);

    // Redirect coinciding with ack and pop.
    cyc("rap_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rap_c0",  1, 1, 0, 0, 0, 1, 32'h0, 0, 0);
    cyc("rap_rd",  1, 1, 1, 1, 32'h42, 1, 32'h4, 1, 32'h0);
    cyc("rap_emp", 1, 0, 1, 0, 0, 1, 32'h40, 0, 0);
    cyc("rap_ack", 1, 1, 1, 0, 0, 1, 32'h40, 0, 0);
    cyc("rap_out", 1, 0, 1, 0, 0, 1, 32'h44, 1, 32'h40);

    // Reset while draining.
    cyc("rdr_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rdr_c0",  1, 1, 0, 0, 0, 1, 32'h0, 0, 0);
    cyc("rdr_rd",  1, 0, 0, 1, 32'h80, 1, 32'h4, 1, 32'h0);
    cyc("rdr_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rdr_c1",  1, 1, 1, 0, 0, 1, 32'h0, 0, 0);
    cyc("rdr_c2",  1, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0);

    // Randomized traffic against the queue model.
    cyc("rnd_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mq.delete(); m_pc = RST_PC; m_paddr = RST_PC; m_pend = 0; m_drain = 0;
    for (int n = 0; n < 4000; n++) begin
      logic        r_rst, r_ack, r_rdy, r_rd;
      logic [31:0] r_rpc, e_addr;
      logic        e_req, e_val, m_ack;
      r_rst = ($urandom_range(0, 199) != 0);
      r_ack = ($urandom_range(0, 2) != 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rd  = ($urandom_range(0, 15) == 0);
      r_rpc = $urandom;
      @(negedge w_clk);
      w_rst_n = r_rst; ack_en = r_ack; w_ready = r_rdy; w_redirect = r_rd; w_redirect_pc = r_rpc;
      #1;
      if (!r_rst) begin
        chk("rnd rst req", {31'b0, w_imem_req}, 32'h0);
        chk("rnd rst valid", {31'b0, w_valid}, 32'h0);
        chk("rnd rst ir", w_ir, NOP);
        mq.delete(); m_pc = RST_PC; m_pend = 0; m_drain = 0;
        continue;
      end
      e_val  = (mq.size() != 0);
      e_req  = m_pend || (!m_drain && mq.size() < 2);
      e_addr = m_pend ? m_paddr : m_pc;
      chk("rnd req", {31'b0, w_imem_req}, {31'b0, e_req});
      if (e_req) chk("rnd addr", w_imem_addr, e_addr);
      chk("rnd valid", {31'b0, w_valid}, {31'b0, e_val});
      if (e_val) begin
        chk("rnd pc", w_pc, mq[0].pc);
        chk("rnd ir", w_ir, mq[0].ir);
      end else begin
        chk("rnd nop", w_ir, NOP);
      end
      m_ack = e_req && r_ack;
      if (r_rd) begin
        mq.delete();
        m_pc    = {r_rpc[31:2], 2'b00};
        m_drain = e_req && !m_ack;
        m_pend  = m_drain;
        m_paddr = e_addr;
      end else if (m_drain) begin
        if (m_ack) begin
          m_drain = 0;
          m_pend  = 0;
        end
      end else begin
        if (e_val && r_rdy) void'(mq.pop_front());
        if (m_ack) begin
          mq.push_back('{pc: m_pc, ir: mem_f(m_pc)});
          m_pc   = m_pc + 32'd4;
          m_pend = 0;
        end else begin
          m_pend  = e_req;
          m_paddr = e_addr;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
